// File: rtl/apb_master_param.sv
// Parametrised APB master: turns a single-outstanding request/response
// handshake into APB SETUP/ACCESS transfers, with PSLVERR capture and an
// optional ACCESS-phase timeout that aborts a stalled transfer.
module apb_master_param #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  // request channel
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [STRB_W-1:0] req_strb_i,
  // response channel
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  // APB
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [STRB_W-1:0] pstrb_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pslverr_i
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit for TIMEOUT<=1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_tmo_cnt;

  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic              w_accept;
  logic              w_done;
  logic              w_abort;
  logic              w_tmo_hit;

  assign w_accept  = (r_state == S_IDLE) && req_valid_i;
  assign w_done    = (r_state == S_ACCESS) && pready_i;
  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
  // Completion wins over an expiring timeout in the same cycle.
  assign w_abort   = (r_state == S_ACCESS) && !pready_i && w_tmo_hit;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture the request; reads drive zero data and zero strobes on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_accept) begin
      r_paddr  <= req_addr_i;
      r_pwrite <= req_write_i;
      r_pwdata <= req_write_i ? req_wdata_i : '0;
      r_pstrb  <= req_write_i ? req_strb_i : '0;
    end
  end

  // Count ACCESS wait cycles; cleared as the transfer enters SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !pready_i && !w_abort) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // One-cycle response pulse; payload holds until the next response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done || w_abort;
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? '0 : prdata_i;
        r_rsp_err     <= pslverr_i;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign req_ready_o   = (r_state == S_IDLE);
  assign psel_o        = (r_state != S_IDLE);
  assign penable_o     = (r_state == S_ACCESS);
  assign paddr_o       = r_paddr;
  assign pwrite_o      = r_pwrite;
  assign pwdata_o      = r_pwdata;
  assign pstrb_o       = r_pstrb;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param (TIMEOUT=4): directed scenarios
// followed by randomized transfers against a transaction-level model.
module tb_apb_master_param;

  localparam int unsigned P_TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;
  int prev_acc_cyc;

  // Last response payload the model expects the DUT to be holding.
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  logic        m_tmo   = 1'b0;

  apb_master_param #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(P_TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_strb_i   (req_strb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .paddr_o      (paddr_o),
    .pwrite_o     (pwrite_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pready_i     (pready_i),
    .prdata_i     (prdata_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One idle cycle: no pulse, response payload held, bus deselected.
  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("idle_rsp_rdata", rsp_rdata_o, m_rdata);
    chk("idle_rsp_err", 32'(rsp_err_o), 32'(m_err));
    chk("idle_rsp_tmo", 32'(rsp_timeout_o), 32'(m_tmo));
    chk("idle_psel", 32'(psel_o), 32'd0);
  endtask

  // Full transfer. Slave raises pready after 'waits' wait cycles. Starts and
  // ends at a negedge with the DUT in IDLE (possibly its response cycle).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input logic serr,
                      input logic [31:0] rd);
    int          cnt;
    int          exp_len;
    logic        exp_tmo;
    logic [31:0] exp_rd;
    logic        exp_err;
    exp_tmo = (waits >= int'(P_TMO));
    exp_len = exp_tmo ? int'(P_TMO) : waits + 1;
    exp_rd  = (exp_tmo || wr) ? 32'd0 : rd;
    exp_err = exp_tmo ? 1'b1 : serr;

    chk("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    @(posedge clk);
    prev_acc_cyc = acc_cyc;
    acc_cyc      = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_write_i = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_strb_i  = 4'($urandom);

    chk("setup_psel", 32'(psel_o), 32'd1);
    chk("setup_penable", 32'(penable_o), 32'd0);
    chk("setup_ready", 32'(req_ready_o), 32'd0);
    chk("setup_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("setup_rsp_err_held", 32'(rsp_err_o), 32'(m_err));
    chk("setup_paddr", paddr_o, addr);
    chk("setup_pwrite", 32'(pwrite_o), 32'(wr));
    chk("setup_pwdata", pwdata_o, wr ? wdata : 32'd0);
    chk("setup_pstrb", 32'(pstrb_o), wr ? 32'(strb) : 32'd0);

    @(negedge clk);
    cnt = 0;
    while (psel_o && penable_o && cnt < 20) begin
      chk("acc_paddr", paddr_o, addr);
      chk("acc_pstrb", 32'(pstrb_o), wr ? 32'(strb) : 32'd0);
      if (cnt == waits) begin
        pready_i  = 1'b1;
        prdata_i  = rd;
        pslverr_i = serr;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = ~serr;
      end
      cnt++;
      @(negedge clk);
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = $urandom;

    chk("access_len", 32'(cnt), 32'(exp_len));
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rsp_rdata", rsp_rdata_o, exp_rd);
    chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    chk("rsp_tmo", 32'(rsp_timeout_o), 32'(exp_tmo));
    chk("rsp_psel", 32'(psel_o), 32'd0);
    chk("rsp_ready", 32'(req_ready_o), 32'd1);
    chk("paddr_hold", paddr_o, addr);
    m_rdata = exp_rd;
    m_err   = exp_err;
    m_tmo   = exp_tmo;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_strb_i  = '0;
    pready_i    = 1'b0;
    prdata_i    = '0;
    pslverr_i   = 1'b0;
    acc_cyc     = 0;
    prev_acc_cyc = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_psel", 32'(psel_o), 32'd0);
    chk("rst_penable", 32'(penable_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_paddr", paddr_o, 32'd0);
    chk("rst_pstrb", 32'(pstrb_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write, zero wait
    xfer(1'b1, 32'h0000_0040, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0);
    idle_cycle();
    // Read, 3 wait states
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 1'b0, 32'h0000_002A);
    idle_cycle();
    // Slave error at completion; opposite pslverr during waits is ignored
    xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 2, 1'b1, 32'hDEAD_BEEF);
    idle_cycle();
    // Timeout abort, then a normal transfer, then ready on the last allowed cycle
    xfer(1'b0, 32'h0000_0300, 32'h0, 4'h0, 10, 1'b0, 32'h1234_5678);
    xfer(1'b1, 32'h0000_0304, 32'h0BAD_F00D, 4'h3, 0, 1'b0, 32'h0);
    idle_cycle();
    xfer(1'b0, 32'h0000_0308, 32'h0, 4'h0, int'(P_TMO) - 1, 1'b0, 32'h0000_0077);
    idle_cycle();
    // Back-to-back writes: each accepted in its predecessor's response cycle
    xfer(1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF, 0, 1'b0, 32'h0);
    xfer(1'b1, 32'h0000_0014, 32'h2222_2222, 4'hF, 0, 1'b0, 32'h0);
    chk("b2b_gap1", 32'(acc_cyc - prev_acc_cyc), 32'd3);
    xfer(1'b1, 32'h0000_0018, 32'h3333_3333, 4'hF, 0, 1'b0, 32'h0);
    chk("b2b_gap2", 32'(acc_cyc - prev_acc_cyc), 32'd3);
    idle_cycle();

    // Asynchronous reset in the middle of a waited read
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h0000_0500;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", 32'(penable_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_psel", 32'(psel_o), 32'd0);
    chk("arst_penable", 32'(penable_o), 32'd0);
    chk("arst_ready", 32'(req_ready_o), 32'd1);
    chk("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    m_rdata = '0;
    m_err   = 1'b0;
    m_tmo   = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid_o), 32'd0);
    end

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
           1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_master_param.md
Name: apb_master_param

Overview:
- Parametrised APB (AMBA3/APB4-style) master. Converts a single-outstanding request/response handshake from a local controller into APB SETUP/ACCESS transfers.
- Adds over the fixed-address master: configurable address/data width, a real request channel (address, data, direction, byte strobes), PSLVERR capture, and an ACCESS-phase timeout with abort.
- Sits between the block's control logic and a single APB slave or decoder.

Parameters:
ADDR_W, 32, APB address width (>=8)
DATA_W, 32, APB data width; must be 8, 16 or 32
TIMEOUT, 16, max ACCESS cycles with pready_i low before abort; 0 disables timeout
STRB_W, DATA_W/8, derived; not to be overridden

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  master can accept request
req_write_i  in  1  1 = write, 0 = read
req_addr_i  in  ADDR_W  transfer address
req_wdata_i  in  DATA_W  write data
req_strb_i  in  STRB_W  write byte strobes
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DATA_W  read data (0 for writes and aborts)
rsp_err_o  out  1  slave error or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
pstrb_o  out  STRB_W  APB byte strobes
pready_i  in  1  slave ready
prdata_i  in  DATA_W  slave read data
pslverr_i  in  1  slave error

Behaviour:
- Reset (async assert, any state): state IDLE. All outputs 0 except req_ready_o=1. Timeout counter 0. An in-flight transfer is dropped with no response.
- FSM states:
  - IDLE: psel=0, penable=0, req_ready_o=1. On req_valid_i&req_ready_o, capture write/addr/wdata/strb into registers and go to SETUP.
  - SETUP (exactly 1 cycle): psel=1, penable=0; then go to ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready_i=1: complete; go to IDLE.
    - pready_i=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort; go to IDLE.
    - Otherwise stay and increment the counter.
- Ready and outputs:
  - req_ready_o is 1 only in IDLE.
  - psel_o, penable_o, req_ready_o are decoded from the state register; no combinational path from inputs.
- APB bus values:
  - paddr_o, pwrite_o, pwdata_o, pstrb_o come from capture registers; stable from SETUP through the end of ACCESS.
  - They hold their last value in IDLE.
  - For reads, the captured pstrb is forced to 0 and pwdata to 0.
- Timeout counter: cleared on entering SETUP; counts ACCESS cycles with pready_i=0.
- Response:
  - Registered, asserted the cycle after completion/abort (first IDLE cycle), high exactly 1 cycle.
  - Normal completion: rsp_rdata_o = prdata_i sampled at the completing edge for reads, 0 for writes. rsp_err_o = pslverr_i at that edge. rsp_timeout_o=0.
  - Abort: rsp_rdata_o=0, rsp_err_o=1, rsp_timeout_o=1.
  - pslverr_i/prdata_i are ignored unless psel&penable&pready_i.
  - rsp_rdata/err/timeout hold until the next response.
- Latency and throughput:
  - Request accepted at edge k → SETUP cycle k+1 → ACCESS from k+2.
  - With zero wait states: rsp_valid_o high in cycle k+3, with req_ready_o=1 in the same cycle.
  - A new request may be accepted in that cycle. Minimum 3 cycles per transfer; 1 outstanding.
- Request inputs are ignored outside IDLE; requester must hold req_valid_i and payload until accepted.
- Simultaneous pready_i=1 and timeout expiry in the same cycle: completion wins, no timeout flag.
- TIMEOUT=0: ACCESS waits indefinitely for pready_i.

Test Plan:
1. Write, zero wait: req addr=0x0000_0040, wdata=0xA5A5_1234, strb=0xF; pready_i=1 in first ACCESS → psel 2 cycles, penable 1 cycle, pwrite=1, pstrb=0xF; rsp_valid pulse 3 cycles after accept, err=0, rdata=0.
2. Read, 3 wait states: addr=0x0000_0100, prdata_i=0x0000_002A with pready_i on 4th ACCESS cycle → ACCESS lasts 4 cycles, pstrb=0, rsp_rdata=0x2A, err=0.
3. Slave error: read with pslverr_i=1 at completion → rsp_err=1, rsp_timeout=0, rsp_rdata=prdata value; pslverr_i=1 while pready_i=0 earlier has no effect.
4. Timeout: TIMEOUT=4, pready_i held 0 → ACCESS exactly 4 cycles, psel drops, rsp_valid with err=1, timeout=1, rdata=0; next request proceeds normally. Repeat with pready_i=1 in the 4th cycle → normal completion, timeout=0.
5. Back-to-back: req_valid held with 3 queued writes (0x10, 0x14, 0x18), zero wait → each accepted the cycle its predecessor's rsp_valid is high; 9 cycles total, addresses in order.
6. Reset mid-ACCESS: assert reset asynchronously during a waited read → psel/penable/rsp_valid go 0 immediately, req_ready_o=1, no response pulse after release.
